// File: rtl/century_time_core.sv
// Century clock time-keeping core: 1 s prescaler, seconds-to-century calendar
// carry chain in run mode, and per-field button adjustment in set mode.
module century_time_core #(
  parameter int TICK_DIV      = 50000000,
  parameter int RESET_CENTURY = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_pulse_1s,
  input  logic [6:0] enable_cnt,
  input  logic       up_button,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [6:0] century,
  output logic       tick_1s
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_btn_prev;
  logic          r_armed;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [4:0]    r_hour;
  logic [4:0]    r_day;
  logic [3:0]    r_month;
  logic [6:0]    r_year;
  logic [6:0]    r_century;

  logic       w_leap;
  logic [4:0] w_dim;
  logic       w_press;
  logic       w_clamp;
  logic       w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_wrap, w_mon_wrap, w_year_wrap;
  logic       w_c_min, w_c_hour, w_c_day, w_c_mon, w_c_year, w_c_cent;

  always_comb begin
    w_leap = ((r_year != 7'd0) && (r_year[1:0] == 2'b00)) ||
             ((r_year == 7'd0) && (r_century[1:0] == 2'b00));
    case (r_month)
      4'd2:                      w_dim = w_leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   w_dim = 5'd30;
      default:                   w_dim = 5'd31;
    endcase
  end

  // r_armed masks the first cycle after reset so a button already held
  // high at release is not mistaken for a fresh press.
  assign w_press = r_armed & up_button & ~r_btn_prev & ~enable_pulse_1s;
  assign w_clamp = (r_day > w_dim);

  assign w_sec_wrap  = (r_sec     == 6'd59);
  assign w_min_wrap  = (r_min     == 6'd59);
  assign w_hour_wrap = (r_hour    == 5'd23);
  assign w_day_wrap  = (r_day     == w_dim);
  assign w_mon_wrap  = (r_month   == 4'd12);
  assign w_year_wrap = (r_year    == 7'd99);

  assign w_c_min  = r_tick   & w_sec_wrap;
  assign w_c_hour = w_c_min  & w_min_wrap;
  assign w_c_day  = w_c_hour & w_hour_wrap;
  assign w_c_mon  = w_c_day  & w_day_wrap;
  assign w_c_year = w_c_mon  & w_mon_wrap;
  assign w_c_cent = w_c_year & w_year_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (!enable_pulse_1s) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + PW'(1);
      r_tick  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_prev <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_btn_prev <= up_button;
      r_armed    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec     <= 6'd0;
      r_min     <= 6'd0;
      r_hour    <= 5'd0;
      r_day     <= 5'd1;
      r_month   <= 4'd1;
      r_year    <= 7'd0;
      r_century <= 7'(RESET_CENTURY);
    end else begin
      if (r_tick) begin
        r_sec <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
        if (w_c_min)  r_min     <= w_min_wrap  ? 6'd0 : r_min + 6'd1;
        if (w_c_hour) r_hour    <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
        if (w_c_day)  r_day     <= w_day_wrap  ? 5'd1 : r_day + 5'd1;
        if (w_c_mon)  r_month   <= w_mon_wrap  ? 4'd1 : r_month + 4'd1;
        if (w_c_year) r_year    <= w_year_wrap ? 7'd0 : r_year + 7'd1;
        if (w_c_cent) r_century <= (r_century == 7'd99) ? 7'd0 : r_century + 7'd1;
      end else if (w_press) begin
        if (enable_cnt[0]) r_sec     <= w_sec_wrap  ? 6'd0 : r_sec + 6'd1;
        if (enable_cnt[1]) r_min     <= w_min_wrap  ? 6'd0 : r_min + 6'd1;
        if (enable_cnt[2]) r_hour    <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
        if (enable_cnt[3]) r_day     <= w_day_wrap  ? 5'd1 : r_day + 5'd1;
        if (enable_cnt[4]) r_month   <= w_mon_wrap  ? 4'd1 : r_month + 4'd1;
        if (enable_cnt[5]) r_year    <= w_year_wrap ? 7'd0 : r_year + 7'd1;
        if (enable_cnt[6]) r_century <= (r_century == 7'd99) ? 7'd0 : r_century + 7'd1;
      end
      // Placed last so it overrides any day update from this same edge.
      if (w_clamp) r_day <= w_dim;
    end
  end

  assign sec     = r_sec;
  assign min     = r_min;
  assign hour    = r_hour;
  assign day     = r_day;
  assign month   = r_month;
  assign year    = r_year;
  assign century = r_century;
  assign tick_1s = r_tick;

endmodule

// File: tb/tb_century_time_core.sv
// Bench for century_time_core: calendar model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_century_time_core;

  localparam int TICK_DIV      = 4;
  localparam int RESET_CENTURY = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_pulse_1s = 1'b0;
  logic [6:0] enable_cnt = 7'd0;
  logic       up_button = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour, day;
  logic [3:0] month;
  logic [6:0] year, century;
  logic       tick_1s;

  int n_tests = 0;
  int n_fail  = 0;

  century_time_core #(.TICK_DIV(TICK_DIV), .RESET_CENTURY(RESET_CENTURY)) dut (
    .clk(clk), .rst(rst), .enable_pulse_1s(enable_pulse_1s), .enable_cnt(enable_cnt),
    .up_button(up_button), .sec(sec), .min(min), .hour(hour), .day(day),
    .month(month), .year(year), .century(century), .tick_1s(tick_1s)
  );

  always #5 clk = ~clk;

  // Calendar model: plain integers, one step per clock edge
  int m_sec, m_min, m_hour, m_day, m_mon, m_year, m_cent;
  int m_run;
  bit m_tick;
  bit m_last;

  function automatic int dim(input int mo, input int y, input int c);
    bit leap;
    leap = (y != 0 && y % 4 == 0) || (y == 0 && c % 4 == 0);
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 0;
    m_cent = RESET_CENTURY; m_run = 0; m_tick = 0;
    m_last = 1'b1;  // no low level observed yet since release
  endtask

  task automatic model_step();
    int  d;
    bit  clamp;
    bit  press;
    d     = dim(m_mon, m_year, m_cent);
    clamp = (m_day > d);
    press = up_button && !m_last;
    m_last = up_button;
    if (m_tick) begin
      m_sec++;
      if (m_sec == 60) begin
        m_sec = 0; m_min++;
        if (m_min == 60) begin
          m_min = 0; m_hour++;
          if (m_hour == 24) begin
            m_hour = 0;
            if (!clamp) begin
              m_day++;
              if (m_day > d) begin
                m_day = 1; m_mon++;
                if (m_mon == 13) begin
                  m_mon = 1; m_year++;
                  if (m_year == 100) begin
                    m_year = 0; m_cent = (m_cent + 1) % 100;
                  end
                end
              end
            end
          end
        end
      end
    end else if (!enable_pulse_1s && press) begin
      if (enable_cnt[0]) m_sec  = (m_sec + 1) % 60;
      if (enable_cnt[1]) m_min  = (m_min + 1) % 60;
      if (enable_cnt[2]) m_hour = (m_hour + 1) % 24;
      if (enable_cnt[3]) m_day  = (m_day >= d) ? 1 : m_day + 1;
      if (enable_cnt[4]) m_mon  = m_mon % 12 + 1;
      if (enable_cnt[5]) m_year = (m_year + 1) % 100;
      if (enable_cnt[6]) m_cent = (m_cent + 1) % 100;
    end
    if (clamp) m_day = d;
    if (enable_pulse_1s) begin
      m_run++;
      m_tick = (m_run % TICK_DIV) == 0;
    end else begin
      m_run  = 0;
      m_tick = 0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_sec",     int'(sec),     m_sec);
    chk("model_min",     int'(min),     m_min);
    chk("model_hour",    int'(hour),    m_hour);
    chk("model_day",     int'(day),     m_day);
    chk("model_month",   int'(month),   m_mon);
    chk("model_year",    int'(year),    m_year);
    chk("model_century", int'(century), m_cent);
    chk("model_tick",    int'(tick_1s), int'(m_tick));
  end

  function automatic int model_field(input int idx);
    case (idx)
      0: return m_sec;
      1: return m_min;
      2: return m_hour;
      3: return m_day;
      4: return m_mon;
      5: return m_year;
      default: return m_cent;
    endcase
  endfunction

  task automatic press(input logic [6:0] mask);
    enable_cnt = mask;
    up_button  = 1'b1;
    @(negedge clk);
    up_button  = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_field(input int idx, input int target);
    int guard;
    guard = 0;
    while (model_field(idx) != target && guard < 250) begin
      press(7'(1 << idx));
      guard++;
    end
    if (guard >= 250) begin
      n_tests++;
      n_fail++;
      $display("FAIL preset_field%0d: stuck at %0d, wanted %0d", idx, model_field(idx), target);
    end
  endtask

  task automatic preset(input int h, input int mi, input int s, input int d,
                        input int mo, input int y, input int c);
    set_field(6, c);
    set_field(5, y);
    set_field(4, mo);
    set_field(3, d);
    set_field(2, h);
    set_field(1, mi);
    set_field(0, s);
  endtask

  task automatic one_tick();
    enable_pulse_1s = 1'b1;
    repeat (TICK_DIV + 1) @(negedge clk);
    enable_pulse_1s = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_sec", sec, 0);
    chk("rst_day", day, 1);
    chk("rst_month", month, 1);
    chk("rst_century", century, 20);
    chk("rst_tick", tick_1s, 0);

    // Prescaler: ticks on edges 4, 8, 12 after run mode begins
    enable_pulse_1s = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(negedge clk);
      chk("tick_cadence", tick_1s, (e % 4 == 0) ? 1 : 0);
      if (e == 5)  chk("sec_after_tick1", sec, 1);
      if (e == 9)  chk("sec_after_tick2", sec, 2);
      if (e == 13) chk("sec_after_tick3", sec, 3);
    end
    enable_pulse_1s = 1'b0;

    // Full rollover into the next century
    preset(23, 59, 59, 31, 12, 99, 20);
    one_tick();
    chk("roll_hour", hour, 0);
    chk("roll_min", min, 0);
    chk("roll_sec", sec, 0);
    chk("roll_day", day, 1);
    chk("roll_month", month, 1);
    chk("roll_year", year, 0);
    chk("roll_century", century, 21);

    // February, leap year 2024
    preset(23, 59, 59, 28, 2, 24, 20);
    one_tick();
    chk("feb2024_day", day, 29);
    chk("feb2024_month", month, 2);
    preset(23, 59, 59, 29, 2, 24, 20);
    one_tick();
    chk("feb2024_mar_day", day, 1);
    chk("feb2024_mar_month", month, 3);

    // 2100 is not leap
    preset(23, 59, 59, 28, 2, 0, 21);
    one_tick();
    chk("feb2100_day", day, 1);
    chk("feb2100_month", month, 3);

    // 2000 is leap
    preset(23, 59, 59, 28, 2, 0, 20);
    one_tick();
    chk("feb2000_day", day, 29);
    chk("feb2000_month", month, 2);

    // Set mode: no carry, held button is a single press
    preset(5, 59, 0, 29, 2, 0, 20);
    press(7'b0000010);
    chk("set_min_wrap", min, 0);
    chk("set_hour_nocarry", hour, 5);
    enable_cnt = 7'b0000010;
    up_button  = 1'b1;
    repeat (10) @(negedge clk);
    up_button  = 1'b0;
    @(negedge clk);
    chk("held_button_once", min, 1);
    press(7'b0000000);
    chk("mask_zero_min", min, 1);
    chk("mask_zero_sec", sec, 0);

    // Presses during run mode are ignored
    enable_pulse_1s = 1'b1;
    press(7'b1111111);
    enable_pulse_1s = 1'b0;
    chk("run_press_sec", sec, 0);
    chk("run_press_month", month, 2);

    // Day clamp after month adjustment
    preset(0, 0, 0, 31, 1, 23, 20);
    enable_cnt = 7'b0010000;
    up_button  = 1'b1;
    @(negedge clk);
    chk("clamp_month", month, 2);
    chk("clamp_day_before", day, 31);
    up_button  = 1'b0;
    @(negedge clk);
    chk("clamp_day_after", day, 28);

    // Asynchronous reset mid-count with button held through release
    enable_pulse_1s = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    up_button = 1'b1;
    enable_cnt = 7'b1111111;
    enable_pulse_1s = 1'b0;
    #1;
    chk("arst_sec", sec, 0);
    chk("arst_min", min, 0);
    chk("arst_hour", hour, 0);
    chk("arst_day", day, 1);
    chk("arst_month", month, 1);
    chk("arst_year", year, 0);
    chk("arst_century", century, 20);
    chk("arst_tick", tick_1s, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_release_sec", sec, 0);
    chk("held_release_day", day, 1);
    up_button = 1'b0;
    @(negedge clk);
    press(7'b1111111);
    chk("all_sec", sec, 1);
    chk("all_min", min, 1);
    chk("all_hour", hour, 1);
    chk("all_day", day, 2);
    chk("all_month", month, 2);
    chk("all_year", year, 1);
    chk("all_century", century, 21);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
